lp_filter_signed: RTL and testbench
===================================

# lp_filter_signed

Parameterizable cascaded first-order IIR low-pass filter (exponential moving average) for signed samples. It is used in the sensor datapath to smooth noisy signed measurements, such as phase or frequency error values, before they are consumed downstream. The filter is a chain of `STAGE_COUNT` identical stages. Each stage computes y += (x − y)/2^SHIFT_BITS with extra fractional precision, so a constant input converges exactly to the same value at the output.

## Interface
Parameters:
- `IN_DATA_BITS`, default 30: signed input width.
- `OUT_DATA_BITS`, default 33: signed output width; must be ≥ `IN_DATA_BITS`.
- `SHIFT_BITS`, default 5: filter coefficient exponent, time constant ≈ 2^SHIFT_BITS cycles; legal range 1..16.
- `STAGE_COUNT`, default 2: number of cascaded IIR stages; legal range 0..8. A value of 0 makes the block a single register.

Ports:
- `CLK`, in, 1: the single clock; all state updates on the rising edge.
- `RESET`, in, 1: asynchronous, active-low reset.
- `CE`, in, 1: clock enable; when low, all state holds.
- `IN_VALUE`, in, `IN_DATA_BITS`, signed: input sample.
- `OUT_VALUE`, out, `OUT_DATA_BITS`, signed: filtered output, same scale as the input (no gain, no fractional bits).

## Operation
- **Input register:** on each rising `CLK` edge with `CE`=1, `IN_VALUE` is sign-extended to `OUT_DATA_BITS` and captured into `x0`.
- **Stage k** (k=1..`STAGE_COUNT`):
  - Holds an accumulator `ACCk`, signed, `OUT_DATA_BITS`+`SHIFT_BITS` bits.
  - Stage output is `yk` = `ACCk` >>> `SHIFT_BITS` (arithmetic shift, i.e. floor), which is `OUT_DATA_BITS` wide.
  - Update when `CE`=1: `ACCk` <= `ACCk` + `x(k-1)` − `yk`, where `x(k-1)` = `y(k-1)` for k>1 and `x0` for k=1.
  - Compute the sum in `OUT_DATA_BITS`+`SHIFT_BITS`+1 bits, then truncate; the result always fits for in-range inputs.
- **Output selection:** `OUT_VALUE` = `yN` for N=`STAGE_COUNT` ≥ 1; `OUT_VALUE` = `x0` for N=0.
- **Exact convergence:** for a constant input X, each stage settles to `ACCk` ∈ [X·2^S, X·2^S+2^S−1], so `yk` = X exactly.
  - Rising input: the increment is ≥1 while `yk` < X.
  - Falling input: the decrement is ≥1 while `yk` > X.
  - No limit cycles for positive or negative inputs.
- **No saturation:** any signed `IN_DATA_BITS` value, including the most negative, is representable.
- **`CE`=0:** all registers (`x0`, every `ACCk`) hold and `OUT_VALUE` is constant.
- **`RESET`=0:** asynchronously clears `x0` and all `ACCk` to 0, so `OUT_VALUE`=0 immediately. Reset takes priority over `CE`. Asserting reset mid-operation discards all filter history.

## Timing
- **Latency:** `IN_VALUE` affects `x0` one enabled cycle after sampling. Each stage adds one enabled cycle before its output first moves. First change at `OUT_VALUE` arrives after 1+`STAGE_COUNT` enabled cycles.
- **Step response of one stage:** the error decays by a factor of (1−2^−S) per enabled cycle; once the error falls below 2^S LSBs of `ACC`, it shrinks by at least 1 per cycle.
- **Settling with S=5 (single stage):** a step of magnitude ≤ 2^29 settles to exact equality within 800 enabled cycles.
- **Settling with S=5, 4 stages:** settles within 2000 enabled cycles.
- **Reset release:** no handshake. Operation starts on the first rising edge with `RESET`=1 and `CE`=1.

## Test plan
Bench: instantiate with `IN_DATA_BITS`=30, `OUT_DATA_BITS`=33, `SHIFT_BITS`=5 at `STAGE_COUNT` = 0, 1, 2, 3 and 4; pulse `RESET` low, then set `CE`=1.
- **Reset:** `RESET` low, arbitrary `IN_VALUE`, `CE`=1 → all `OUT_VALUE`=0. Asserting `RESET` mid-run forces `OUT_VALUE`=0 without waiting for a clock edge.
- **Step up:** `IN_VALUE`=109377165 for 2000 cycles →
  - `STAGE_COUNT`=0 gives 109377165 after 1 cycle.
  - All other stage counts give exactly 109377165 by cycle 2000, monotonic non-decreasing with no overshoot.
  - The first nonzero output of stage count N appears at cycle N+1.
- **Half step:** `IN_VALUE`=54688582 for 1000 cycles → `STAGE_COUNT`=0 and 1 give exactly 54688582 by cycle 1000, monotonic non-increasing. Then restore 109377165 for 1000 cycles → 109377165 again.
- **Negative swing:** `IN_VALUE`=−218754330 for 1000 cycles → output monotonic decreasing. `STAGE_COUNT`=1 reaches exactly −218754330 by cycle 1000; all stage counts reach it exactly after 2000 cycles. Checks floor rounding on negatives and the absence of a limit cycle.
- **`CE` hold:** drop `CE` for 50 cycles mid-transient → `OUT_VALUE` frozen. Raise `CE` → the trajectory resumes identically to an uninterrupted run, shifted by 50 cycles.
- **Extremes:** `IN_VALUE` = −2^29, then 2^29−1, each held 3000 cycles → output equals the input exactly, with no overflow or wrap of any intermediate value.

Source files
------------

// File: rtl/lp_filter_signed.sv
// Cascaded first-order IIR low-pass filter for signed samples.
// Each stage integrates (x - y) with SHIFT_BITS extra fraction bits.
module lp_filter_signed #(
  parameter int IN_DATA_BITS  = 30,
  parameter int OUT_DATA_BITS = 33,
  parameter int SHIFT_BITS    = 5,
  parameter int STAGE_COUNT   = 2
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            CE,
  input  logic signed [IN_DATA_BITS-1:0]  IN_VALUE,
  output logic signed [OUT_DATA_BITS-1:0] OUT_VALUE
);

  localparam int OW = OUT_DATA_BITS;
  localparam int AW = OUT_DATA_BITS + SHIFT_BITS;

  logic signed [OW-1:0] x0_q;
  logic signed [OW-1:0] x0_d;
  logic signed [OW-1:0] y [STAGE_COUNT+1];

  // Sign-extend the incoming sample to the output width
  always_comb begin
    x0_d = OW'(IN_VALUE);
  end

  // Input register, cleared by reset, held while CE is low
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x0_q <= '0;
    end else if (CE) begin
      x0_q <= x0_d;
    end
  end

  assign y[0] = x0_q;

  for (genvar k = 0; k < STAGE_COUNT; k++) begin : g_stage
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;

    // Floor of acc / 2^S; upper bits beyond OW are pure sign copies
    assign y[k+1] = acc_q[AW-1:SHIFT_BITS];

    // acc + x - y; the wrap-free result always fits in AW bits
    always_comb begin
      acc_d = acc_q + AW'(y[k]) - AW'(y[k+1]);
    end

    // Accumulator register for this stage
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        acc_q <= '0;
      end else if (CE) begin
        acc_q <= acc_d;
      end
    end
  end

  assign OUT_VALUE = y[STAGE_COUNT];

endmodule

// File: tb/tb_lp_filter_signed.sv
// Bench for lp_filter_signed at STAGE_COUNT 0..4 side by side.
// Outputs are compared against an integer EMA model each cycle.
module tb_lp_filter_signed;

  localparam int NI = 5;
  localparam longint XUP = 109377165;
  localparam longint XHALF = 54688582;
  localparam longint XNEG = -218754330;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ce;
  logic signed [29:0] in_v;
  logic signed [32:0] outs [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lp_filter_signed #(
      .IN_DATA_BITS (30),
      .OUT_DATA_BITS(33),
      .SHIFT_BITS   (5),
      .STAGE_COUNT  (g)
    ) u_dut (
      .CLK      (clk),
      .RESET    (rst_n),
      .CE       (ce),
      .IN_VALUE (in_v),
      .OUT_VALUE(outs[g])
    );
  end

  int checks = 0;
  int errors = 0;

  longint mx0 [NI];
  longint macc [NI][4];
  longint prev [NI];

  function automatic longint fdiv(longint a);
    if (a >= 0) return a / 32;
    return -((-a + 31) / 32);
  endfunction

  function automatic longint mout(int n);
    if (n == 0) return mx0[0];
    return fdiv(macc[n][n-1]);
  endfunction

  task automatic model_clear();
    for (int n = 0; n < NI; n++) begin
      mx0[n] = 0;
      for (int k = 0; k < 4; k++) macc[n][k] = 0;
    end
  endtask

  task automatic model_edge();
    longint xin;
    if (!rst_n) begin
      model_clear();
    end else if (ce) begin
      for (int n = 0; n < NI; n++) begin
        for (int k = n - 1; k >= 0; k--) begin
          xin = (k == 0) ? mx0[n] : fdiv(macc[n][k-1]);
          macc[n][k] = macc[n][k] + xin - fdiv(macc[n][k]);
        end
        mx0[n] = longint'(in_v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    in_v = 30'($urandom);
    model_clear();
    #1;
    for (int n = 0; n < NI; n++) begin
      checks++;
      if (outs[n] !== 33'sd0) begin
        errors++;
        $display("FAIL reset_async n=%0d got %0d exp 0", n, outs[n]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      in_v = 30'($urandom);
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (outs[n] !== 33'sd0) begin
          errors++;
          $display("FAIL reset_hold n=%0d got %0d exp 0", n, outs[n]);
        end
      end
    end
    in_v = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_step_up();
    in_v = 30'(XUP);
    for (int n = 0; n < NI; n++) prev[n] = 0;
    for (int c = 1; c <= 2000; c++) begin
      step();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== mout(n)) begin
          errors++;
          $display("FAIL step_model n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], mout(n));
        end
        checks++;
        if ((outs[n] != 0) !== (c >= n + 1)) begin
          errors++;
          $display("FAIL step_latency n=%0d cyc=%0d got %0d nonzero exp %0d",
                   n, c, outs[n], (c >= n + 1));
        end
        checks++;
        if (longint'(outs[n]) < prev[n] || longint'(outs[n]) > XUP) begin
          errors++;
          $display("FAIL step_monotonic n=%0d cyc=%0d got %0d prev %0d max %0d",
                   n, c, outs[n], prev[n], XUP);
        end
        prev[n] = longint'(outs[n]);
      end
    end
    for (int n = 0; n < NI; n++) begin
      checks++;
      if (longint'(outs[n]) !== XUP) begin
        errors++;
        $display("FAIL step_final n=%0d got %0d exp %0d", n, outs[n], XUP);
      end
    end
  endtask

  task automatic test_half_step();
    in_v = 30'(XHALF);
    for (int n = 0; n < NI; n++) prev[n] = longint'(outs[n]);
    for (int c = 1; c <= 1000; c++) begin
      step();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== mout(n)) begin
          errors++;
          $display("FAIL half_model n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], mout(n));
        end
        checks++;
        if (longint'(outs[n]) > prev[n]) begin
          errors++;
          $display("FAIL half_monotonic n=%0d cyc=%0d got %0d prev %0d",
                   n, c, outs[n], prev[n]);
        end
        prev[n] = longint'(outs[n]);
      end
    end
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (longint'(outs[n]) !== XHALF) begin
        errors++;
        $display("FAIL half_final n=%0d got %0d exp %0d", n, outs[n], XHALF);
      end
    end
    in_v = 30'(XUP);
    for (int c = 1; c <= 1000; c++) begin
      step();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== mout(n)) begin
          errors++;
          $display("FAIL restore_model n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], mout(n));
        end
      end
    end
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (longint'(outs[n]) !== XUP) begin
        errors++;
        $display("FAIL restore_final n=%0d got %0d exp %0d", n, outs[n], XUP);
      end
    end
  endtask

  task automatic test_negative();
    in_v = 30'(XNEG);
    for (int n = 0; n < NI; n++) prev[n] = longint'(outs[n]);
    for (int c = 1; c <= 2000; c++) begin
      step();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== mout(n)) begin
          errors++;
          $display("FAIL neg_model n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], mout(n));
        end
        if (n < 2) begin
          checks++;
          if (longint'(outs[n]) > prev[n]) begin
            errors++;
            $display("FAIL neg_monotonic n=%0d cyc=%0d got %0d prev %0d",
                     n, c, outs[n], prev[n]);
          end
        end
        prev[n] = longint'(outs[n]);
      end
      if (c == 1000) begin
        checks++;
        if (longint'(outs[1]) !== XNEG) begin
          errors++;
          $display("FAIL neg_stage1_1000 got %0d exp %0d", outs[1], XNEG);
        end
      end
    end
    for (int n = 0; n < NI; n++) begin
      checks++;
      if (longint'(outs[n]) !== XNEG) begin
        errors++;
        $display("FAIL neg_final n=%0d got %0d exp %0d", n, outs[n], XNEG);
      end
    end
  endtask

  task automatic test_ce_hold();
    longint snap [NI];
    in_v = '0;
    for (int c = 0; c < 100; c++) step();
    ce = 1'b0;
    in_v = 30'($urandom);
    for (int n = 0; n < NI; n++) snap[n] = mout(n);
    for (int c = 1; c <= 50; c++) begin
      step();
      in_v = 30'($urandom);
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== snap[n]) begin
          errors++;
          $display("FAIL ce_frozen n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], snap[n]);
        end
      end
    end
    ce = 1'b1;
    in_v = '0;
    for (int c = 1; c <= 200; c++) begin
      step();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== mout(n)) begin
          errors++;
          $display("FAIL ce_resume n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], mout(n));
        end
      end
    end
  endtask

  task automatic test_extremes();
    longint ext [2];
    ext[0] = -(64'sd1 <<< 29);
    ext[1] = (64'sd1 <<< 29) - 1;
    for (int e = 0; e < 2; e++) begin
      in_v = 30'(ext[e]);
      for (int c = 1; c <= 3000; c++) begin
        step();
        for (int n = 0; n < NI; n++) begin
          checks++;
          if (longint'(outs[n]) !== mout(n)) begin
            errors++;
            $display("FAIL ext_model e=%0d n=%0d cyc=%0d got %0d exp %0d",
                     e, n, c, outs[n], mout(n));
          end
        end
      end
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== ext[e]) begin
          errors++;
          $display("FAIL ext_final e=%0d n=%0d got %0d exp %0d",
                   e, n, outs[n], ext[e]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 400; c++) begin
      in_v = 30'($urandom);
      ce = ($urandom_range(0, 3) != 0);
      step();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== mout(n)) begin
          errors++;
          $display("FAIL rand_model n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], mout(n));
        end
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midrun();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    for (int n = 0; n < NI; n++) begin
      checks++;
      if (outs[n] !== 33'sd0) begin
        errors++;
        $display("FAIL reset_midrun n=%0d got %0d exp 0", n, outs[n]);
      end
    end
    step();
    rst_n = 1'b1;
    in_v = 30'(XUP);
    for (int c = 1; c <= 10; c++) begin
      step();
      for (int n = 0; n < NI; n++) begin
        checks++;
        if (longint'(outs[n]) !== mout(n)) begin
          errors++;
          $display("FAIL reset_restart n=%0d cyc=%0d got %0d exp %0d",
                   n, c, outs[n], mout(n));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    ce = 1'b0;
    in_v = '0;
    model_clear();
    test_reset();
    test_step_up();
    test_half_step();
    test_negative();
    test_ce_hold();
    test_extremes();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
